// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time parameter helpers for the ring FIFO.
package fifo_pkg;

  // Occupancy counter width: must represent every value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when the parameter set is legal: width at least 1, depth a power of
  // two no smaller than 2, and the almost-full threshold inside 1..depth.
  function automatic bit params_ok(input int width, input int depth, input int af_level);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_ring_ctrl.sv
// Pointer, occupancy and status control for the ring FIFO. Decides which
// push/pop requests are accepted and hands write/read addresses to the storage.
module fifo_ring_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_err_i,
  output logic          o_wrEn,
  output logic [AW-1:0] o_wrAddr,
  output logic [AW-1:0] o_rdAddr,
  output logic          full_o,
  output logic          empty_o,
  output logic          pnding_o,
  output logic          almost_full_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic w_full;
  logic w_empty;
  logic w_popOk;
  logic w_pushOk;

  // A pop needs stored data; a push needs room, or a slot freed by a pop in
  // the same cycle. A pop into an empty FIFO is refused even if a push lands.
  always_comb begin
    w_full   = (r_count == CW'(DEPTH));
    w_empty  = (r_count == '0);
    w_popOk  = pop_i && !w_empty;
    w_pushOk = push_i && (!w_full || w_popOk);
  end

  // Pointers wrap naturally at DEPTH; count moves only when exactly one side is accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_popOk)  r_rdPtr <= r_rdPtr + AW'(1);
      if (w_pushOk && !w_popOk)      r_count <= r_count + CW'(1);
      else if (!w_pushOk && w_popOk) r_count <= r_count - CW'(1);
    end
  end

  // Sticky error flags; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push_i && !w_pushOk) r_overflow <= 1'b1;
      else if (clr_err_i)      r_overflow <= 1'b0;
      if (pop_i && !w_popOk)   r_underflow <= 1'b1;
      else if (clr_err_i)      r_underflow <= 1'b0;
    end
  end

  assign o_wrEn        = w_pushOk;
  assign o_wrAddr      = r_wrPtr;
  assign o_rdAddr      = r_rdPtr;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign pnding_o      = !w_empty;
  assign almost_full_o = (r_count >= CW'(AF_LEVEL));
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;

endmodule

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO: storage array plus read path, selectable between a
// registered read and first-word-fall-through.
module fifo_ring
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int FWFT     = 0,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             pnding_o,
  output logic             almost_full_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL)) begin : g_badParams
    $error("fifo_ring: WIDTH must be >=1, DEPTH a power of two >=2, AF_LEVEL in 1..DEPTH");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wrEn;
  logic [AW-1:0]    w_wrAddr;
  logic [AW-1:0]    w_rdAddr;

  fifo_ring_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_ctrl (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .clr_err_i     (clr_err_i),
    .o_wrEn        (w_wrEn),
    .o_wrAddr      (w_wrAddr),
    .o_rdAddr      (w_rdAddr),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .pnding_o      (pnding_o),
    .almost_full_o (almost_full_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  // Storage has no reset; only slots between the pointers are ever observed.
  always_ff @(posedge clk_i) begin
    if (w_wrEn) r_mem[w_wrAddr] <= data_i;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; forced to zero while empty so stale RAM never leaks out.
    always_comb begin
      data_o = '0;
      if (!empty_o) data_o = r_mem[w_rdAddr];
    end
  end else begin : g_regRead
    logic [WIDTH-1:0] r_data;
    logic             w_popOk;

    assign w_popOk = pop_i && !empty_o;

    // Registered read: capture the head word on an accepted pop, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       r_data <= '0;
      else if (w_popOk) r_data <= r_mem[w_rdAddr];
    end

    assign data_o = r_data;
  end

endmodule

// File: tb/tb_fifo_ring.sv
// Self-checking bench for fifo_ring: directed table, test-plan sequences and
// random traffic against a queue-based reference, plus a small FWFT instance.
module tb_fifo_ring;

  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic        clk = 1'b0;
  logic        rstN;
  logic        push, pop, clrErr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        full, empty, pnding, almostFull, ovf, unf;
  logic [4:0]  count;

  logic        fRstN;
  logic        fPush, fPop;
  logic [31:0] fDataIn;
  logic [31:0] fDataOut;
  logic        fFull, fEmpty, fPnding, fAf, fOvf, fUnf;
  logic [4:0]  fCount;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic        mOvf, mUnf;
  logic [31:0] mData;

  always #5 clk = ~clk;

  fifo_ring #(.WIDTH(32), .DEPTH(DEPTH), .AF_LEVEL(AF), .FWFT(0)) uDut (
    .clk_i(clk), .rst_i(rstN), .push_i(push), .data_i(dataIn), .pop_i(pop),
    .clr_err_i(clrErr), .data_o(dataOut), .full_o(full), .empty_o(empty),
    .pnding_o(pnding), .almost_full_o(almostFull), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf)
  );

  fifo_ring #(.WIDTH(32), .DEPTH(DEPTH), .AF_LEVEL(AF), .FWFT(1)) uFwft (
    .clk_i(clk), .rst_i(fRstN), .push_i(fPush), .data_i(fDataIn), .pop_i(fPop),
    .clr_err_i(1'b0), .data_o(fDataOut), .full_o(fFull), .empty_o(fEmpty),
    .pnding_o(fPnding), .almost_full_o(fAf), .count_o(fCount),
    .overflow_o(fOvf), .underflow_o(fUnf)
  );

  typedef struct {
    logic        push, pop, clr;
    logic [31:0] data;
    int          expCount;
    logic        expOvf, expUnf;
    logic [31:0] expData;
  } vec_t;

  vec_t tbl[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    int sz;
    sz = mq.size();
    checkOutput({tag, " count"},  32'(count), 32'(sz));
    checkOutput({tag, " full"},   32'(full), 32'(sz == DEPTH));
    checkOutput({tag, " empty"},  32'(empty), 32'(sz == 0));
    checkOutput({tag, " pnding"}, 32'(pnding), 32'(sz != 0));
    checkOutput({tag, " afull"},  32'(almostFull), 32'(sz >= AF));
    checkOutput({tag, " ovf"},    32'(ovf), 32'(mOvf));
    checkOutput({tag, " unf"},    32'(unf), 32'(mUnf));
    checkOutput({tag, " data"},   dataOut, mData);
  endtask

  // Drive one cycle of requests, advance the reference, then compare.
  task automatic applyStimulus(input logic p, input logic q, input logic c,
                               input logic [31:0] d, input string tag);
    bit popOk, pushOk;
    push = p; pop = q; clrErr = c; dataIn = d;
    @(posedge clk);
    popOk  = q && (mq.size() > 0);
    pushOk = p && ((mq.size() < DEPTH) || popOk);
    if (popOk)  mData = mq.pop_front();
    if (pushOk) mq.push_back(d);
    mOvf = (p && !pushOk) ? 1'b1 : (c ? 1'b0 : mOvf);
    mUnf = (q && !popOk)  ? 1'b1 : (c ? 1'b0 : mUnf);
    #1;
    checkModel(tag);
    push = 0; pop = 0; clrErr = 0;
  endtask

  task automatic modelReset();
    mq.delete();
    mOvf = 0; mUnf = 0; mData = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " data"},   dataOut, 32'h0);
    checkOutput({tag, " full"},   32'(full), 32'h0);
    checkOutput({tag, " empty"},  32'(empty), 32'h1);
    checkOutput({tag, " pnding"}, 32'(pnding), 32'h0);
    checkOutput({tag, " afull"},  32'(almostFull), 32'h0);
    checkOutput({tag, " count"},  32'(count), 32'h0);
    checkOutput({tag, " ovf"},    32'(ovf), 32'h0);
    checkOutput({tag, " unf"},    32'(unf), 32'h0);
  endtask

  initial begin
    bit seenAA;
    int bias;

    //                push pop clr data        cnt ovf unf data_o
    tbl[0] = '{1, 0, 0, 32'h11, 1, 0, 0, 32'h00};
    tbl[1] = '{1, 0, 0, 32'h22, 2, 0, 0, 32'h00};
    tbl[2] = '{0, 1, 0, 32'h00, 1, 0, 0, 32'h11};
    tbl[3] = '{1, 1, 0, 32'h33, 1, 0, 0, 32'h22};
    tbl[4] = '{0, 1, 0, 32'h00, 0, 0, 0, 32'h33};
    tbl[5] = '{0, 1, 0, 32'h00, 0, 0, 1, 32'h33};
    tbl[6] = '{0, 0, 1, 32'h00, 0, 0, 0, 32'h33};
    tbl[7] = '{1, 1, 1, 32'h44, 1, 0, 1, 32'h33};
    tbl[8] = '{0, 1, 0, 32'h00, 0, 0, 1, 32'h44};
    tbl[9] = '{0, 0, 1, 32'h00, 0, 0, 0, 32'h44};

    push = 0; pop = 0; clrErr = 0; dataIn = 0;
    fPush = 0; fPop = 0; fDataIn = 0;
    rstN = 0; fRstN = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rstN = 1; fRstN = 1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].data, $sformatf("tbl%0d", i));
      checkOutput($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].expCount));
      checkOutput($sformatf("tbl%0d ovf", i), 32'(ovf), 32'(tbl[i].expOvf));
      checkOutput($sformatf("tbl%0d unf", i), 32'(unf), 32'(tbl[i].expUnf));
      checkOutput($sformatf("tbl%0d data", i), dataOut, tbl[i].expData);
    end

    // Fill with 0..F then drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 32'(i), "fill");
    checkOutput("fill full", 32'(full), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, 0, 0, "drain");
      checkOutput("drain order", dataOut, 32'(i));
    end
    checkOutput("drain empty", 32'(empty), 32'h1);
    checkOutput("drain no errors", 32'({ovf, unf}), 32'h0);

    // Almost-full threshold
    for (int i = 0; i < AF; i++) applyStimulus(1, 0, 0, 32'(i + 32'h200), "af fill");
    checkOutput("af at 14", 32'(almostFull), 32'h1);
    applyStimulus(0, 1, 0, 0, "af pop");
    checkOutput("af at 13", 32'(almostFull), 32'h0);

    // Overflow: fill, push 0xAA with no pop, then clear
    while (mq.size() < DEPTH) applyStimulus(1, 0, 0, 32'(mq.size() + 32'h300), "ovf fill");
    applyStimulus(1, 0, 0, 32'hAA, "ovf push");
    checkOutput("ovf set", 32'(ovf), 32'h1);
    checkOutput("ovf count", 32'(count), 32'd16);
    applyStimulus(0, 0, 1, 0, "ovf clr");
    checkOutput("ovf cleared", 32'(ovf), 32'h0);

    // Full with simultaneous push/pop across several pointer wraps
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 0, 32'(i + 32'h1000), "full pp");
      checkOutput("full pp count", 32'(count), 32'd16);
    end
    seenAA = 0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, 0, 0, "full drain");
      if (dataOut == 32'hAA) seenAA = 1;
    end
    checkOutput("0xAA never read", 32'(seenAA), 32'h0);
    checkOutput("no overflow in pp", 32'(ovf), 32'h0);

    // Empty with push and pop together
    applyStimulus(1, 1, 0, 32'h55, "empty pp");
    checkOutput("empty pp unf", 32'(unf), 32'h1);
    checkOutput("empty pp count", 32'(count), 32'd1);
    applyStimulus(0, 1, 1, 0, "empty pp pop");
    checkOutput("empty pp data", dataOut, 32'h55);

    // Random traffic in phases of differing fill pressure
    for (int ph = 0; ph < 3; ph++) begin
      bias = (ph == 0) ? 75 : (ph == 1) ? 30 : 50;
      for (int i = 0; i < 800; i++) begin
        applyStimulus($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                      $urandom_range(0, 99) < 5, $urandom, "rand");
      end
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'(i + 32'h700), "pre-rst");
    applyStimulus(1, 0, 0, 32'h777, "pre-rst full");
    push = 1; dataIn = 32'h999;
    #2 rstN = 0;
    #1;
    checkResetValues("async rst");
    push = 0;
    modelReset();
    @(negedge clk) rstN = 1;
    applyStimulus(1, 0, 0, 32'hBEEF, "post-rst push");
    applyStimulus(0, 1, 0, 0, "post-rst pop");
    checkOutput("post-rst data", dataOut, 32'hBEEF);

    // FWFT instance
    @(posedge clk); #1;
    fPush = 1; fDataIn = 32'h12;
    @(posedge clk); #1;
    fPush = 0;
    checkOutput("fwft visible", fDataOut, 32'h12);
    checkOutput("fwft count1", 32'(fCount), 32'd1);
    fPush = 1; fDataIn = 32'h34;
    @(posedge clk); #1;
    checkOutput("fwft head held", fDataOut, 32'h12);
    fPush = 1; fPop = 1; fDataIn = 32'h56;
    @(posedge clk); #1;
    fPop = 0;
    checkOutput("fwft next head", fDataOut, 32'h34);
    checkOutput("fwft count2", 32'(fCount), 32'd2);
    fPush = 1; fDataIn = 32'h78;
    #2 fRstN = 0;
    #1;
    checkOutput("fwft rst data", fDataOut, 32'h0);
    checkOutput("fwft rst count", 32'(fCount), 32'h0);
    checkOutput("fwft rst flags", 32'({fFull, fEmpty, fPnding, fAf, fOvf, fUnf}), 32'b010000);
    fPush = 0;
    @(negedge clk) fRstN = 1;
    fPush = 1; fDataIn = 32'h9A;
    @(posedge clk); #1;
    fPush = 0;
    checkOutput("fwft post-rst head", fDataOut, 32'h9A);
    checkOutput("fwft post-rst count", 32'(fCount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
